dfb_spi_ctrl: RTL and testbench

Register-mapped SPI master for the DFB1 CPLD. It serves the 16-byte register window at 0x00F1DFB0-F: ID, DFB config and SPI data/status. It sequences byte-wide SPI transfers on the P50/P61/P106/P110 header, and drives the config byte that selects FPU clock speed and feature disables. The bus side is a synchronised request/acknowledge pair. The top level derives BUS_REQ from AS/DS/address decode and converts BUS_ACK into DSACK.

---
 rtl/dfb_spi_pkg.sv | 28 ++
 rtl/dfb_spi_ctrl_if.sv | 30 +++
 rtl/dfb_spi_shift.sv | 107 ++++++++++
 rtl/dfb_spi_ctrl.sv | 132 +++++++++++++
 tb/tb_dfb_spi_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dfb_spi_pkg.sv
// Shared definitions for the DFB1 SPI controller: register offsets, reset values
// and the shift-engine state encoding.
package dfb_spi_pkg;

    localparam logic [3:0] REG_ID   = 4'h0;
    localparam logic [3:0] REG_CFG  = 4'h2;
    localparam logic [3:0] REG_DATA = 4'h4;
    localparam logic [3:0] REG_STAT = 4'h6;

    localparam logic [7:0] CFG_RST     = 8'hFD;
    localparam logic [7:0] STAT_RST    = 8'h03;
    localparam logic [7:0] DATA_RST    = 8'hFF;
    localparam logic [7:0] RD_UNMAPPED = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StDone
    } spi_state_e;

    // Status byte layout: {busy, overrun, 4'b0, slow, cs}
    function automatic logic [7:0] stat_pack(input logic busy, input logic ovr,
                                             input logic slow, input logic cs);
        return {busy, ovr, 4'b0000, slow, cs};
    endfunction

endpackage

// File: rtl/dfb_spi_ctrl_if.sv
// Synchronised request/acknowledge register bus between the CPLD decode logic
// and the SPI controller.
interface dfb_spi_ctrl_if;

    logic       BUS_REQ;
    logic       BUS_RW;
    logic [3:0] BUS_ADDR;
    logic [7:0] BUS_WDATA;
    logic [7:0] BUS_RDATA;
    logic       BUS_ACK;

    modport master (
        output BUS_REQ,
        output BUS_RW,
        output BUS_ADDR,
        output BUS_WDATA,
        input  BUS_RDATA,
        input  BUS_ACK
    );

    modport slave (
        input  BUS_REQ,
        input  BUS_RW,
        input  BUS_ADDR,
        input  BUS_WDATA,
        output BUS_RDATA,
        output BUS_ACK
    );

endinterface

// File: rtl/dfb_spi_shift.sv
// Byte-wide SPI mode-0 shift engine: half-period divider, SCK/MOSI generation,
// MISO capture and a done strobe on the final falling SCK edge.
module dfb_spi_shift
    import dfb_spi_pkg::*;
#(
    parameter int unsigned FAST_DIV = 2,
    parameter int unsigned SLOW_DIV = 64
) (
    input  logic       CLKOSC,
    input  logic       RST,
    input  logic       start,
    input  logic       slow,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte
);

    localparam int unsigned MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int unsigned CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [CNT_W-1:0] FAST_RELOAD = CNT_W'(FAST_DIV - 1);
    localparam logic [CNT_W-1:0] SLOW_RELOAD = CNT_W'(SLOW_DIV - 1);

    spi_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic             slow_q;
    logic [7:0]       tx_sr_q;
    logic [7:0]       rx_sr_q;
    logic             sck_q;
    logic             mosi_q;
    logic             busy_q;
    logic [CNT_W-1:0] reload;

    // Speed is frozen at transfer start; later status writes wait for the next byte.
    assign reload = slow_q ? SLOW_RELOAD : FAST_RELOAD;

    assign done    = (state_q == StShiftHi) && (cnt_q == '0) && (bit_q == 3'd7);
    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign busy    = busy_q;
    assign rx_byte = rx_sr_q;

    always_ff @(posedge CLKOSC) begin
        if (!RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            slow_q  <= STAT_RST[1];
            tx_sr_q <= DATA_RST;
            rx_sr_q <= DATA_RST;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else if (start) begin
            state_q <= StShiftLo;
            cnt_q   <= slow ? SLOW_RELOAD : FAST_RELOAD;
            bit_q   <= '0;
            slow_q  <= slow;
            tx_sr_q <= tx_byte;
            sck_q   <= 1'b0;
            mosi_q  <= tx_byte[7];
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                StShiftLo: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        sck_q   <= 1'b1;
                        rx_sr_q <= {rx_sr_q[6:0], miso};
                        cnt_q   <= reload;
                        state_q <= StShiftHi;
                    end
                end
                StShiftHi: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        sck_q <= 1'b0;
                        cnt_q <= reload;
                        if (bit_q == 3'd7) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            mosi_q  <= 1'b1;
                        end else begin
                            state_q <= StShiftLo;
                            bit_q   <= bit_q + 3'd1;
                            tx_sr_q <= {tx_sr_q[6:0], 1'b1};
                            mosi_q  <= tx_sr_q[6];
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/dfb_spi_ctrl.sv
// DFB1 register window (ID, config, SPI data/status) with request/acknowledge
// handshake, driving the SPI shift engine and the config byte.
module dfb_spi_ctrl
    import dfb_spi_pkg::*;
#(
    parameter int unsigned FAST_DIV = 2,
    parameter int unsigned SLOW_DIV = 64,
    parameter logic [7:0]  ID_VALUE = 8'h01
) (
    input  logic           CLKOSC,
    input  logic           RST,
    dfb_spi_ctrl_if.slave  bus,
    output logic [7:0]     CFG,
    output logic           SPI_SCK,
    output logic           SPI_MOSI,
    input  logic           SPI_MISO,
    output logic           SPI_CS,
    output logic           SPI_BUSY
);

    logic       req_q;
    logic       ack_q;
    logic [7:0] rdata_q;
    logic [7:0] cfg_q;
    logic [7:0] tx_q;
    logic [7:0] tx_d;
    logic [7:0] rx_q;
    logic       slow_q;
    logic       cs_q;
    logic       ovr_q;

    logic       accept;
    logic       can_start;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] rx_byte;
    logic [7:0] rd_mux;

    assign accept = bus.BUS_REQ && !req_q;

    // The cycle the engine finishes counts as idle, so a write then chains a new byte.
    assign can_start = !busy || done;
    assign start     = accept && !bus.BUS_RW && (bus.BUS_ADDR == REG_DATA) && can_start;
    assign tx_d      = start ? bus.BUS_WDATA : tx_q;

    always_comb begin
        rd_mux = RD_UNMAPPED;
        case (bus.BUS_ADDR)
            REG_ID:   rd_mux = ID_VALUE;
            REG_CFG:  rd_mux = cfg_q;
            REG_DATA: rd_mux = done ? rx_byte : rx_q;
            REG_STAT: rd_mux = stat_pack(busy, ovr_q, slow_q, cs_q);
            default:  rd_mux = RD_UNMAPPED;
        endcase
    end

    always_ff @(posedge CLKOSC) begin
        if (!RST) begin
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= RD_UNMAPPED;
            cfg_q   <= CFG_RST;
            tx_q    <= DATA_RST;
            rx_q    <= DATA_RST;
            slow_q  <= STAT_RST[1];
            cs_q    <= STAT_RST[0];
            ovr_q   <= STAT_RST[6];
        end else begin
            req_q <= bus.BUS_REQ;
            tx_q  <= tx_d;

            if (!bus.BUS_REQ) begin
                ack_q <= 1'b0;
            end else if (accept) begin
                ack_q <= 1'b1;
            end

            if (done) begin
                rx_q <= rx_byte;
            end

            if (accept) begin
                if (bus.BUS_RW) begin
                    rdata_q <= rd_mux;
                    if (bus.BUS_ADDR == REG_STAT) begin
                        ovr_q <= 1'b0;
                    end
                end else begin
                    case (bus.BUS_ADDR)
                        REG_CFG: cfg_q <= bus.BUS_WDATA;
                        REG_DATA: begin
                            if (!can_start) begin
                                ovr_q <= 1'b1;
                            end
                        end
                        REG_STAT: begin
                            slow_q <= bus.BUS_WDATA[1];
                            cs_q   <= bus.BUS_WDATA[0];
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    dfb_spi_shift #(
        .FAST_DIV (FAST_DIV),
        .SLOW_DIV (SLOW_DIV)
    ) u_shift (
        .CLKOSC  (CLKOSC),
        .RST     (RST),
        .start   (start),
        .slow    (slow_q),
        .tx_byte (tx_d),
        .miso    (SPI_MISO),
        .sck     (SPI_SCK),
        .mosi    (SPI_MOSI),
        .busy    (busy),
        .done    (done),
        .rx_byte (rx_byte)
    );

    assign bus.BUS_ACK   = ack_q;
    assign bus.BUS_RDATA = rdata_q;
    assign CFG           = cfg_q;
    assign SPI_CS        = cs_q;
    assign SPI_BUSY      = busy;

endmodule

// File: tb/tb_dfb_spi_ctrl.sv
// Bench for dfb_spi_ctrl: register reads/writes, SPI byte transfers in both
// speeds, overrun, chained transfers, reset abort and unmapped offsets.
module tb_dfb_spi_ctrl;

    localparam int unsigned FAST_DIV = 2;
    localparam int unsigned SLOW_DIV = 64;

    logic       CLKOSC = 1'b0;
    logic       RST    = 1'b0;
    logic [7:0] CFG;
    logic       SPI_SCK;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic       SPI_CS;
    logic       SPI_BUSY;

    dfb_spi_ctrl_if bus ();

    dfb_spi_ctrl #(
        .FAST_DIV (FAST_DIV),
        .SLOW_DIV (SLOW_DIV),
        .ID_VALUE (8'h01)
    ) dut (
        .CLKOSC   (CLKOSC),
        .RST      (RST),
        .bus      (bus),
        .CFG      (CFG),
        .SPI_SCK  (SPI_SCK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_MISO (SPI_MISO),
        .SPI_CS   (SPI_CS),
        .SPI_BUSY (SPI_BUSY)
    );

    always #5 CLKOSC = ~CLKOSC;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] miso_byte = 8'hFF;

    // SPI-side monitor state, written only by the monitor process below.
    int         cyc        = 0;
    int         nfall      = 0;
    int         nrise      = 0;
    int         nedge      = 0;
    int         busy_start = 0;
    int         busy_len   = 0;
    int         rise_cyc   = 0;
    int         half_per   = 0;
    logic [7:0] mosi_cap   = 8'h00;
    logic       sck_prev   = 1'b0;
    logic       busy_prev  = 1'b0;

    // Slave model: present the next MISO bit after every falling SCK edge.
    assign SPI_MISO = miso_byte[3'd7 - nfall[2:0]];

    always @(negedge CLKOSC) begin
        cyc++;
        if (SPI_BUSY === 1'b1 && !busy_prev) begin
            busy_start = cyc;
            nfall      = 0;
            nrise      = 0;
            nedge      = 0;
        end
        if (SPI_BUSY === 1'b0 && busy_prev) begin
            busy_len = cyc - busy_start;
        end
        if (SPI_SCK === 1'b1 && !sck_prev) begin
            mosi_cap = {mosi_cap[6:0], SPI_MOSI};
            rise_cyc = cyc;
            nrise++;
            nedge++;
        end
        if (SPI_SCK === 1'b0 && sck_prev) begin
            half_per = cyc - rise_cyc;
            nfall++;
            nedge++;
        end
        sck_prev  = (SPI_SCK === 1'b1);
        busy_prev = (SPI_BUSY === 1'b1);
    end

    task automatic bus_xfer(input logic rw, input logic [3:0] addr, input logic [7:0] wd,
                            output logic [7:0] rd);
        bit seen;
        bus.BUS_REQ   = 1'b1;
        bus.BUS_RW    = rw;
        bus.BUS_ADDR  = addr;
        bus.BUS_WDATA = wd;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge CLKOSC);
            seen = (bus.BUS_ACK === 1'b1);
        end
        rd = bus.BUS_RDATA;
        n_total++;
        if (!seen) $display("FAIL ack_rise addr=%h got ACK=%b want 1", addr, bus.BUS_ACK);
        else n_pass++;
        bus.BUS_REQ = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge CLKOSC);
            seen = (bus.BUS_ACK === 1'b0);
        end
        n_total++;
        if (!seen) $display("FAIL ack_fall addr=%h got ACK=%b want 0", addr, bus.BUS_ACK);
        else n_pass++;
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [7:0] wd);
        logic [7:0] unused_rd;
        bus_xfer(1'b0, addr, wd, unused_rd);
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [7:0] rd);
        bus_xfer(1'b1, addr, 8'h00, rd);
    endtask

    task automatic wait_idle(input int bound);
        int i;
        i = 0;
        while (SPI_BUSY !== 1'b0 && i < bound) begin
            @(negedge CLKOSC);
            i++;
        end
        #1;
        n_total++;
        if (SPI_BUSY !== 1'b0) $display("FAIL busy_timeout got BUSY=%b want 0", SPI_BUSY);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [3:0] addrs[4];
        logic [7:0] exps[4];
        logic [7:0] got;
        logic [7:0] e;
        addrs = '{4'h0, 4'h2, 4'h4, 4'h6};
        exps  = '{8'h01, 8'hFD, 8'hFF, 8'h03};
        RST = 1'b0;
        repeat (3) @(negedge CLKOSC);
        n_total++;
        if (SPI_SCK !== 1'b0) $display("FAIL rst_sck got %b want 0", SPI_SCK); else n_pass++;
        n_total++;
        if (SPI_MOSI !== 1'b1) $display("FAIL rst_mosi got %b want 1", SPI_MOSI); else n_pass++;
        n_total++;
        if (SPI_CS !== 1'b1) $display("FAIL rst_cs got %b want 1", SPI_CS); else n_pass++;
        n_total++;
        if (SPI_BUSY !== 1'b0) $display("FAIL rst_busy got %b want 0", SPI_BUSY); else n_pass++;
        n_total++;
        if (bus.BUS_ACK !== 1'b0) $display("FAIL rst_ack got %b want 0", bus.BUS_ACK);
        else n_pass++;
        n_total++;
        if (bus.BUS_RDATA !== 8'hFF) $display("FAIL rst_rdata got %h want ff", bus.BUS_RDATA);
        else n_pass++;
        n_total++;
        if (CFG !== 8'hFD) $display("FAIL rst_cfg got %h want fd", CFG); else n_pass++;
        RST = 1'b1;
        @(negedge CLKOSC);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            bus_read(addrs[i], got);
            e = exp_q.pop_front();
            n_total++;
            if (got !== e) $display("FAIL rst_read_%h got %h want %h", addrs[i], got, e);
            else n_pass++;
        end
    endtask

    task automatic test_fast_transfer();
        logic [7:0] got;
        logic [7:0] e;
        bus_write(4'h6, 8'h00);
        n_total++;
        if (SPI_CS !== 1'b0) $display("FAIL fast_cs got %b want 0", SPI_CS); else n_pass++;
        miso_byte = 8'h3C;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        bus_write(4'h4, 8'hA5);
        wait_idle(200);
        e = exp_q.pop_front();
        n_total++;
        if (mosi_cap !== e) $display("FAIL fast_mosi got %h want %h", mosi_cap, e); else n_pass++;
        n_total++;
        if (nrise != 8) $display("FAIL fast_nrise got %0d want 8", nrise); else n_pass++;
        n_total++;
        if (busy_len != 32) $display("FAIL fast_busy_len got %0d want 32", busy_len);
        else n_pass++;
        n_total++;
        if (half_per != FAST_DIV) $display("FAIL fast_half got %0d want %0d", half_per, FAST_DIV);
        else n_pass++;
        n_total++;
        if (SPI_MOSI !== 1'b1 || SPI_SCK !== 1'b0)
            $display("FAIL fast_idle_lines got mosi=%b sck=%b want 1 0", SPI_MOSI, SPI_SCK);
        else n_pass++;
        bus_read(4'h4, got);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL fast_rx got %h want %h", got, e); else n_pass++;
    endtask

    task automatic test_slow_transfer();
        logic [7:0] got;
        logic [7:0] e;
        bus_write(4'h6, 8'h02);
        miso_byte = 8'h5A;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        bus_write(4'h4, 8'hFF);
        bus_read(4'h6, got);
        n_total++;
        if (got !== 8'h82) $display("FAIL slow_status got %h want 82", got); else n_pass++;
        wait_idle(3000);
        e = exp_q.pop_front();
        n_total++;
        if (mosi_cap !== e) $display("FAIL slow_mosi got %h want %h", mosi_cap, e); else n_pass++;
        n_total++;
        if (busy_len != 1024) $display("FAIL slow_busy_len got %0d want 1024", busy_len);
        else n_pass++;
        n_total++;
        if (half_per != SLOW_DIV) $display("FAIL slow_half got %0d want %0d", half_per, SLOW_DIV);
        else n_pass++;
        bus_read(4'h4, got);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL slow_rx got %h want %h", got, e); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [7:0] got;
        logic [7:0] e;
        bus_write(4'h6, 8'h00);
        miso_byte = 8'h96;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h96);
        bus_write(4'h4, 8'hA5);
        bus_write(4'h4, 8'h11);
        bus_read(4'h6, got);
        n_total++;
        if (got !== 8'hC0) $display("FAIL ovr_status_set got %h want c0", got); else n_pass++;
        bus_read(4'h6, got);
        n_total++;
        if (got !== 8'h80) $display("FAIL ovr_status_clr got %h want 80", got); else n_pass++;
        wait_idle(200);
        e = exp_q.pop_front();
        n_total++;
        if (mosi_cap !== e) $display("FAIL ovr_mosi got %h want %h", mosi_cap, e); else n_pass++;
        n_total++;
        if (busy_len != 32) $display("FAIL ovr_busy_len got %0d want 32", busy_len); else n_pass++;
        bus_read(4'h4, got);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL ovr_rx got %h want %h", got, e); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic [7:0] e;
        // Read of DATA on the very edge the byte completes
        miso_byte = 8'hC6;
        exp_q.push_back(8'hC6);
        bus_write(4'h4, 8'h3C);
        repeat (30) @(negedge CLKOSC);
        bus_read(4'h4, got);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL b2b_read_on_done got %h want %h", got, e); else n_pass++;
        wait_idle(50);
        // Write of DATA on the completion edge chains a second byte without a gap
        miso_byte = 8'h81;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h81);
        bus_write(4'h4, 8'h12);
        repeat (30) @(negedge CLKOSC);
        bus_write(4'h4, 8'h34);
        wait_idle(300);
        n_total++;
        if (busy_len != 64) $display("FAIL b2b_busy_len got %0d want 64", busy_len); else n_pass++;
        n_total++;
        if (nrise != 16) $display("FAIL b2b_nrise got %0d want 16", nrise); else n_pass++;
        e = exp_q.pop_front();
        n_total++;
        if (mosi_cap !== e) $display("FAIL b2b_mosi got %h want %h", mosi_cap, e); else n_pass++;
        bus_read(4'h6, got);
        n_total++;
        if (got !== 8'h00) $display("FAIL b2b_status got %h want 00", got); else n_pass++;
        bus_read(4'h4, got);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL b2b_rx got %h want %h", got, e); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        bus_write(4'h2, 8'h5A);
        n_total++;
        if (CFG !== 8'h5A) $display("FAIL mid_cfg_write got %h want 5a", CFG); else n_pass++;
        miso_byte = 8'h00;
        bus_write(4'h4, 8'hC3);
        for (int i = 0; i < 100 && nedge < 6; i++) begin
            @(negedge CLKOSC);
            #1;
        end
        n_total++;
        if (nedge != 6) $display("FAIL mid_edges got %0d want 6", nedge); else n_pass++;
        RST = 1'b0;
        @(negedge CLKOSC);
        n_total++;
        if (SPI_SCK !== 1'b0) $display("FAIL mid_sck got %b want 0", SPI_SCK); else n_pass++;
        n_total++;
        if (SPI_MOSI !== 1'b1) $display("FAIL mid_mosi got %b want 1", SPI_MOSI); else n_pass++;
        n_total++;
        if (SPI_CS !== 1'b1) $display("FAIL mid_cs got %b want 1", SPI_CS); else n_pass++;
        n_total++;
        if (SPI_BUSY !== 1'b0) $display("FAIL mid_busy got %b want 0", SPI_BUSY); else n_pass++;
        n_total++;
        if (CFG !== 8'hFD) $display("FAIL mid_cfg got %h want fd", CFG); else n_pass++;
        RST = 1'b1;
        @(negedge CLKOSC);
        exp_q.push_back(8'hFF);
        bus_read(4'h4, got);
        n_total++;
        if (got !== exp_q[0]) $display("FAIL mid_rx got %h want %h", got, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
    endtask

    task automatic test_unmapped();
        logic [7:0] got;
        bus_read(4'h8, got);
        n_total++;
        if (got !== 8'hFF) $display("FAIL unmap_read_8 got %h want ff", got); else n_pass++;
        bus_read(4'h3, got);
        n_total++;
        if (got !== 8'hFF) $display("FAIL unmap_read_3 got %h want ff", got); else n_pass++;
        bus_write(4'hE, 8'h00);
        bus_write(4'h3, 8'h00);
        bus_write(4'h0, 8'h00);
        n_total++;
        if (CFG !== 8'hFD) $display("FAIL unmap_cfg got %h want fd", CFG); else n_pass++;
        bus_read(4'h0, got);
        n_total++;
        if (got !== 8'h01) $display("FAIL unmap_id got %h want 01", got); else n_pass++;
    endtask

    task automatic test_held_request();
        logic [7:0] got;
        logic [7:0] e;
        int ack_hi;
        bus_write(4'h6, 8'h00);
        miso_byte = 8'h24;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h24);
        bus.BUS_REQ   = 1'b1;
        bus.BUS_RW    = 1'b0;
        bus.BUS_ADDR  = 4'h4;
        bus.BUS_WDATA = 8'h5A;
        ack_hi = 0;
        repeat (10) begin
            @(negedge CLKOSC);
            if (bus.BUS_ACK === 1'b1) ack_hi++;
        end
        n_total++;
        if (ack_hi != 10) $display("FAIL held_ack_cycles got %0d want 10", ack_hi); else n_pass++;
        bus.BUS_REQ = 1'b0;
        @(negedge CLKOSC);
        n_total++;
        if (bus.BUS_ACK !== 1'b0) $display("FAIL held_ack_drop got %b want 0", bus.BUS_ACK);
        else n_pass++;
        bus_read(4'h6, got);
        n_total++;
        if (got !== 8'h80) $display("FAIL held_single_access got %h want 80", got); else n_pass++;
        wait_idle(200);
        e = exp_q.pop_front();
        n_total++;
        if (mosi_cap !== e) $display("FAIL held_mosi got %h want %h", mosi_cap, e); else n_pass++;
        bus_read(4'h4, got);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL held_rx got %h want %h", got, e); else n_pass++;
    endtask

    initial begin
        bus.BUS_REQ   = 1'b0;
        bus.BUS_RW    = 1'b0;
        bus.BUS_ADDR  = 4'h0;
        bus.BUS_WDATA = 8'h00;
        test_reset();
        test_fast_transfer();
        test_slow_transfer();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_unmapped();
        test_held_request();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
